sopc_mem_arbiter: RTL and testbench
===================================

// Module: sopc_mem_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM between the instruction-fetch master (I) and the
//  load/store master (D) of the minimal MIPS SOPC. Serialises accesses with a small FSM and
//  returns a one-cycle ack per request. Drives per-master stall flags into the pipeline control unit.
// PARAMETERS
//  ADDR_W   32  address width, byte address, both masters and RAM
//  DATA_W   32  data width
//  RAM_LAT  1   RAM read latency in cycles after ram_ce; legal 1..15
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       asynchronous reset, active-low
//  i_req      in   1       I request, held high until i_ack
//  i_addr     in   ADDR_W  I address (read only)
//  i_rdata    out  DATA_W  I read data, valid in the i_ack cycle
//  i_ack      out  1       I transfer complete, one-cycle pulse
//  d_req      in   1       D request, held high until d_ack
//  d_we       in   1       D write enable
//  d_addr     in   ADDR_W  D address
//  d_sel      in   DATA_W/8 D byte enables (writes)
//  d_wdata    in   DATA_W  D write data
//  d_rdata    out  DATA_W  D read data, valid in the d_ack cycle
//  d_ack      out  1       D transfer complete, one-cycle pulse
//  ram_ce     out  1       RAM access strobe, one cycle per access
//  ram_we     out  1       RAM write enable, qualified by ram_ce
//  ram_addr   out  ADDR_W  RAM address
//  ram_sel    out  DATA_W/8 RAM byte enables (all ones on reads)
//  ram_wdata  out  DATA_W  RAM write data
//  ram_rdata  in   DATA_W  RAM read data, valid RAM_LAT cycles after ram_ce
//  stall_i    out  1       combinational: i_req & ~i_ack
//  stall_d    out  1       combinational: d_req & ~d_ack
// BEHAVIOUR
//  - Reset (rst low, async): FSM=IDLE, counter=0, all registered outputs 0 (incl. rdata regs).
//  - FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. All ram_* and ack/rdata are registered.
//    IDLE : on any req, pick winner, latch its addr/we/sel/wdata and owner bit; next ISSUE.
//    ISSUE: ram_ce=1 for exactly this cycle; counter loaded with RAM_LAT-1; next WAIT.
//    WAIT : decrement; when counter==0 the ram_rdata sample is captured into winner's rdata reg
//           (reads only; on writes rdata regs hold); next DONE.
//    DONE : winner's ack=1 for one cycle; next IDLE. Loser sees no ack and stays stalled.
//  - Latency: req first seen high in cycle N -> ram_ce in N+1 -> ack in N+RAM_LAT+2.
//    Minimum gap between acks is RAM_LAT+3 cycles (one IDLE cycle between accesses).
//  - Priority (default): D wins over I on simultaneous req (D is the older instruction).
//  - I accesses always drive ram_we=0, ram_sel=all ones.
//  - Req dropped before ack: protocol violation; access still completes and ack still pulses.
//  - Req sampled only in IDLE; a req rising during ISSUE/WAIT/DONE waits for next IDLE.
//  - i_ack and d_ack are never high in the same cycle; ram_ce never high two cycles in a row.
//  - rst low mid-access: FSM aborts to IDLE immediately, no ack issued, ram_ce drops.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: on simultaneous req the master NOT granted last wins; last-grant
//   flag resets to D (so first contested grant goes to I); uncontested requests unaffected.
//  Not defined: fixed priority, D always wins contested arbitration.
// TESTING
//  1 Reset: hold rst=0 5 cycles with i_req=1 -> ram_ce=0, acks=0, rdata=0, stall_i=1.
//  2 Single I read, RAM_LAT=1, i_addr=0x0000_0010, RAM returns 0x3401_1100 -> ram_ce at N+1,
//    i_ack at N+3 with i_rdata=0x3401_1100, exactly one ram_ce.
//  3 D write d_addr=0x20,d_sel=4'b0011,d_wdata=0xDEAD_BEEF -> ram_we=1,ram_sel=0011 with ce;
//    d_ack pulses; d_rdata unchanged.
//  4 i_req and d_req rise same cycle (fixed priority) -> D acked first, I acked RAM_LAT+3
//    cycles later; with ARB_ROUND_ROBIN_EN, I first then D; repeat contest alternates.
//  5 RAM_LAT=3 read -> ack exactly 5 cycles after req; rdata equals ram_rdata 3 cycles after ce.
//  6 Pull rst low during WAIT -> outputs 0 immediately; after release a held req restarts from IDLE
//    and gets exactly one ack.

Source files
------------

// File: rtl/sopc_mem_arbiter.sv
// sopc_mem_arbiter: shares one single-port synchronous RAM between the instruction-fetch
// master (I) and the load/store master (D). Accesses are serialised by an
// IDLE -> ISSUE -> WAIT -> DONE FSM. Every RAM strobe, ack and read-data output is registered.
// Optional build macro: ARB_ROUND_ROBIN_EN selects round-robin arbitration for contested
// requests. When it is not defined, D always wins a contested request.
module sopc_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RAM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_ack,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W/8-1:0]   d_sel,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_ack,
    output logic                  ram_ce,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W/8-1:0]   ram_sel,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata,
    output logic                  stall_i,
    output logic                  stall_d
);

    localparam logic [3:0] LatM1 = 4'(RAM_LAT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q;
    logic       owner_d_q;  // 1: the access in flight belongs to D
    logic       start;
    logic       capture;
    logic       win_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_q;  // 1: the last contested grant went to D

    // Contested requests go to whichever master lost the previous contest
    always_comb begin
        win_d = d_req & (~i_req | ~last_d_q);
    end

    // Only contested grants move the round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d_q <= 1'b1;
        end else if (start && i_req && d_req) begin
            last_d_q <= win_d;
        end
    end
`else
    // Fixed priority: D is the older instruction and always wins
    always_comb begin
        win_d = d_req;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and the one-cycle start/capture strobes
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    start   = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Latch the winning request and drive the registered RAM strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_d_q <= 1'b0;
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_sel   <= '0;
            ram_wdata <= '0;
        end else begin
            ram_ce <= start;
            if (start) begin
                owner_d_q <= win_d;
                ram_addr  <= win_d ? d_addr : i_addr;
                ram_we    <= win_d & d_we;
                ram_sel   <= (win_d && d_we) ? d_sel : '1;
                ram_wdata <= win_d ? d_wdata : '0;
            end
        end
    end

    // Latency counter: loaded during ISSUE, counts down through WAIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 4'd0;
        end else if (state_q == StIssue) begin
            cnt_q <= LatM1;
        end else if (state_q == StWait && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Capture read data for the owner and pulse its ack in the DONE cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_rdata <= '0;
            d_rdata <= '0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
        end else begin
            i_ack <= capture & ~owner_d_q;
            d_ack <= capture & owner_d_q;
            if (capture && !ram_we) begin
                if (owner_d_q) begin
                    d_rdata <= ram_rdata;
                end else begin
                    i_rdata <= ram_rdata;
                end
            end
        end
    end

    assign stall_i = i_req & ~i_ack;
    assign stall_d = d_req & ~d_ack;

endmodule

// File: tb/tb_sopc_mem_arbiter.sv
// Self-checking bench for sopc_mem_arbiter: one instance with RAM_LAT=1 carries the main
// traffic, a second instance with RAM_LAT=3 checks the longer read latency. Expected acks
// (owner, read data, cycle) are queued when requests are driven and popped on each ack.
module tb_sopc_mem_arbiter;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t sb[$];
    exp_t sb3[$];

    // Instance 1 (RAM_LAT = 1)
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_sel = '0;
    logic [31:0] i_rdata1, d_rdata1, ram_addr1, ram_wdata1, rd1;
    logic        i_ack1, d_ack1, ram_ce1, ram_we1, stall_i1, stall_d1;
    logic [3:0]  ram_sel1;
    logic [31:0] mem1 [0:63];

    // Instance 3 (RAM_LAT = 3), I master only
    logic        i_req3 = 1'b0;
    logic [31:0] i_addr3 = '0;
    logic [31:0] i_rdata3, d_rdata3, ram_addr3, ram_wdata3;
    logic        i_ack3, d_ack3, ram_ce3, ram_we3, stall_i3, stall_d3;
    logic [3:0]  ram_sel3;
    logic [31:0] rd3 [0:2];

    // Observations from the instance-1 RAM port
    int          ce_cnt = 0, ce_cyc = 0, ack_cnt = 0, ce3_cyc = 0;
    logic        ce_prev = 1'b0, ce_we = 1'b0;
    logic [3:0]  ce_sel = '0;
    logic [31:0] ce_addr = '0, ce_wdata = '0;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_last_d = 1'b1;
`endif

    sopc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata1), .i_ack(i_ack1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel), .d_wdata(d_wdata),
        .d_rdata(d_rdata1), .d_ack(d_ack1),
        .ram_ce(ram_ce1), .ram_we(ram_we1), .ram_addr(ram_addr1), .ram_sel(ram_sel1),
        .ram_wdata(ram_wdata1), .ram_rdata(rd1),
        .stall_i(stall_i1), .stall_d(stall_d1)
    );

    sopc_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .i_req(i_req3), .i_addr(i_addr3), .i_rdata(i_rdata3), .i_ack(i_ack3),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_sel(4'h0), .d_wdata(32'h0),
        .d_rdata(d_rdata3), .d_ack(d_ack3),
        .ram_ce(ram_ce3), .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_sel(ram_sel3),
        .ram_wdata(ram_wdata3), .ram_rdata(rd3[2]),
        .stall_i(stall_i3), .stall_d(stall_d3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int k);
        if (k == 4) return 32'h3401_1100;
        return 32'hC0DE_0000 + 32'(k) * 32'h0101;
    endfunction

    // RAM model, latency 1; junk on the bus whenever no read is due
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int k = 0; k < 64; k++) mem1[k] <= init_word(k);
        end else if (ram_ce1 && ram_we1) begin
            for (int b = 0; b < 4; b++)
                if (ram_sel1[b]) mem1[ram_addr1[7:2]][8*b +: 8] <= ram_wdata1[8*b +: 8];
        end
        rd1 <= (ram_ce1 && !ram_we1) ? mem1[ram_addr1[7:2]] : (32'hBAD0_0000 | 32'(cyc));
    end

    // RAM model, latency 3, read only
    always @(posedge clk) begin
        rd3[0] <= ram_ce3 ? init_word(int'(ram_addr3[7:2])) : (32'hBAD3_0000 | 32'(cyc));
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void push(input logic is_d, input logic [31:0] rdata, input int c);
        exp_t e;
        e.is_d = is_d; e.rdata = rdata; e.cyc = c;
        sb.push_back(e);
    endfunction

    // Instance-1 monitor: RAM strobe capture and scoreboard pop on every ack
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (ram_ce1) begin
                check("ce_back_to_back", 32'(ce_prev), 0);
                ce_cnt++; ce_cyc = cyc; ce_we = ram_we1; ce_sel = ram_sel1;
                ce_addr = ram_addr1; ce_wdata = ram_wdata1;
            end
            ce_prev = ram_ce1;
            if (i_ack1 || d_ack1) begin
                ack_cnt++;
                check("ack_exclusive", 32'(i_ack1 & d_ack1), 0);
                if (sb.size() == 0) begin
                    check("ack_unexpected", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("ack_owner_d", 32'(d_ack1), 32'(e.is_d));
                    check("ack_cycle", cyc, e.cyc);
                    check("ack_rdata", d_ack1 ? d_rdata1 : i_rdata1, e.rdata);
                end
            end
        end else begin
            ce_prev = 1'b0;
        end
    end

    // Instance-3 monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (ram_ce3) begin
                ce3_cyc = cyc;
                check("lat3_ce_addr", ram_addr3, i_addr3);
                check("lat3_ce_sel", 32'(ram_sel3), 32'hF);
            end
            if (i_ack3) begin
                check("lat3_quiet", {29'd0, d_ack3, stall_d3, ram_we3}, 0);
                check("lat3_stall_i", 32'(stall_i3), 0);
                check("lat3_d_rdata", d_rdata3, 0);
                if (sb3.size() == 0) begin
                    check("lat3_unexpected", sb3.size(), 1);
                end else begin
                    e = sb3.pop_front();
                    check("lat3_ack_cycle", cyc, e.cyc);
                    check("lat3_rdata", i_rdata3, e.rdata);
                end
            end
        end
    end

    // Let outstanding requests finish, dropping each one after its ack
    task automatic run_until_idle();
        logic si, sd;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            si = i_ack1; sd = d_ack1;
            @(posedge clk); #1;
            if (si) i_req = 1'b0;
            if (sd) d_req = 1'b0;
            if (!i_req && !d_req) break;
        end
        check("req_completed", {30'd0, i_req, d_req}, 0);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int n, c0, a0;
        logic d_first;
        logic [31:0] exp_d;

        // 1: reset held with i_req high
        i_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rst_ram_ce", {31'd0, ram_ce1}, 0);
            check("rst_acks", {30'd0, i_ack1, d_ack1}, 0);
            check("rst_rdata", i_rdata1 | d_rdata1, 0);
            check("rst_stall_i", {31'd0, stall_i1}, 1);
            check("rst_stall_d", {31'd0, stall_d1}, 0);
        end
        @(posedge clk); #1 i_req = 1'b0;
        @(posedge clk); #1 rst = 1'b1;

        // 2: single I read
        @(posedge clk); #1;
        i_addr = 32'h10; i_req = 1'b1; n = cyc; c0 = ce_cnt;
        push(1'b0, 32'h3401_1100, n + 3);
        run_until_idle();
        check("t2_ce_cycle", ce_cyc, n + 1);
        check("t2_ce_count", ce_cnt - c0, 1);
        check("t2_ce_addr", ce_addr, 32'h10);
        check("t2_ce_we_sel", {27'd0, ce_we, ce_sel}, 32'h0F);

        // 3: D write, then read back the merged word
        exp_d = 32'h0;
        @(posedge clk); #1;
        d_addr = 32'h20; d_sel = 4'b0011; d_wdata = 32'hDEAD_BEEF; d_we = 1'b1; d_req = 1'b1;
        n = cyc;
        push(1'b1, exp_d, n + 3);
        run_until_idle();
        check("t3_ce_cycle", ce_cyc, n + 1);
        check("t3_ce_we_sel", {27'd0, ce_we, ce_sel}, 32'h13);
        check("t3_ce_addr", ce_addr, 32'h20);
        check("t3_ce_wdata", ce_wdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        d_we = 1'b0; d_sel = 4'b0000; d_req = 1'b1; n = cyc;
        exp_d = (init_word(8) & 32'hFFFF_0000) | 32'h0000_BEEF;
        push(1'b1, exp_d, n + 3);
        run_until_idle();
        check("t3_rd_ce_we_sel", {27'd0, ce_we, ce_sel}, 32'h0F);

        // 4: simultaneous requests, twice
        for (int r = 0; r < 2; r++) begin
            @(posedge clk); #1;
            i_addr = 32'h10; d_addr = 32'h24; d_we = 1'b0; i_req = 1'b1; d_req = 1'b1;
            n = cyc;
`ifdef ARB_ROUND_ROBIN_EN
            d_first = ~rr_last_d;
            rr_last_d = d_first;
`else
            d_first = 1'b1;
`endif
            if (d_first) begin
                push(1'b1, init_word(9), n + 3);
                push(1'b0, 32'h3401_1100, n + 7);
            end else begin
                push(1'b0, 32'h3401_1100, n + 3);
                push(1'b1, init_word(9), n + 7);
            end
            run_until_idle();
        end

        // 5: RAM_LAT = 3 read on the second instance
        @(posedge clk); #1;
        i_addr3 = 32'h40; i_req3 = 1'b1; n = cyc;
        begin
            exp_t e;
            e.is_d = 1'b0; e.rdata = init_word(16); e.cyc = n + 5;
            sb3.push_back(e);
        end
        for (int k = 0; k < 30 && sb3.size() != 0; k++) @(negedge clk);
        check("t5_sb3_drained", sb3.size(), 0);
        check("t5_ce_cycle", ce3_cyc, n + 1);
        @(posedge clk); #1 i_req3 = 1'b0;

        // 6: reset during WAIT, then a held request restarts cleanly
        @(posedge clk); #1;
        i_addr = 32'h10; i_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #2 rst = 1'b0;
        #1;
        check("t6_ram_ce", {31'd0, ram_ce1}, 0);
        check("t6_acks", {30'd0, i_ack1, d_ack1}, 0);
        check("t6_i_rdata", i_rdata1, 0);
        check("t6_d_rdata", d_rdata1, 0);
        check("t6_stall_i", {31'd0, stall_i1}, 1);
        sb.delete();
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b1;
        n = cyc; a0 = ack_cnt;
        push(1'b0, 32'h3401_1100, n + 3);
        run_until_idle();
        repeat (6) @(negedge clk);
        check("t6_one_ack", ack_cnt - a0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
